// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch/decode stage ahead of the global control FSM. Holds the
//               program counter and instruction register, and splits the held
//               instruction word into opcode, register, immediate and
//               instruction-class fields.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, all state updates on posedge
//   reset          in   asynchronous active-low reset
//   pc_en          in   advance PC this cycle
//   pc_mux_en      in   1: PC += sext(IR[7:0]); 0: PC += 1
//   IR_enable      in   capture mem_data_in into IR this cycle
//   mem_data_in    in   instruction word read at pc_out
//   pc_out         out  current PC (program memory address)
//   opcode_out     out  {IR[15:12], IR[7:4]}
//   rdst_out       out  {1'b0, IR[11:8]}
//   rsrc_out       out  {1'b0, IR[3:0]}
//   immediate_out  out  IR[7:0]
//   flag_type_out  out  instruction class
//   instr_valid    out  IR holds a fetched word
//   illegal        out  held word decodes to an unknown class
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              pc_mux_en,
  input  logic              IR_enable,
  input  logic [15:0]       mem_data_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [7:0]        opcode_out,
  output logic [4:0]        rdst_out,
  output logic [4:0]        rsrc_out,
  output logic [7:0]        immediate_out,
  output logic [3:0]        flag_type_out,
  output logic              instr_valid,
  output logic              illegal
);

  localparam logic [3:0] C_CLS_NONE   = 4'b0000;
  localparam logic [3:0] C_CLS_RTYPE  = 4'b0001;
  localparam logic [3:0] C_CLS_IMM    = 4'b0010;
  localparam logic [3:0] C_CLS_BRANCH = 4'b0011;
  localparam logic [3:0] C_CLS_LOAD   = 4'b0100;
  localparam logic [3:0] C_CLS_STORE  = 4'b0101;
  localparam logic [3:0] C_CLS_JUMP   = 4'b0110;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] w_disp;
  logic [3:0]        w_op_hi;
  logic [3:0]        w_ext;
  logic [3:0]        w_class;
  logic              w_unknown;

  // Displacement always comes from the IR value held before this edge, so a
  // simultaneous fetch never affects the branch target being computed.
  assign w_disp = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    if (pc_en) begin
      pc_d = pc_mux_en ? (pc_q + w_disp) : (pc_q + {{(ADDR_W-1){1'b0}}, 1'b1});
    end
    if (IR_enable) begin
      ir_d    = mem_data_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign w_op_hi = ir_q[15:12];
  assign w_ext   = ir_q[7:4];

  always_comb begin
    w_class   = C_CLS_NONE;
    w_unknown = 1'b0;
    unique case (w_op_hi)
      4'b0000: w_class = C_CLS_RTYPE;
      4'b0100: begin
        unique case (w_ext)
          4'b0000: w_class = C_CLS_LOAD;
          4'b0100: w_class = C_CLS_STORE;
          4'b1100: w_class = C_CLS_JUMP;
          default: w_unknown = 1'b1;
        endcase
      end
      4'b1100: w_class = C_CLS_BRANCH;
      4'b0001, 4'b0101, 4'b1001,
      4'b1011, 4'b1101, 4'b0011: w_class = C_CLS_IMM;
      default: w_unknown = 1'b1;
    endcase
  end

  // Every decoded field reads as zero until the first word has been fetched.
  assign pc_out        = pc_q;
  assign instr_valid   = valid_q;
  assign opcode_out    = valid_q ? {w_op_hi, w_ext}    : 8'h00;
  assign rdst_out      = valid_q ? {1'b0, ir_q[11:8]}  : 5'd0;
  assign rsrc_out      = valid_q ? {1'b0, ir_q[3:0]}   : 5'd0;
  assign immediate_out = valid_q ? ir_q[7:0]           : 8'h00;
  assign flag_type_out = valid_q ? w_class             : C_CLS_NONE;
  assign illegal       = valid_q & w_unknown;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit: decode vector table,
//               directed multi-cycle sequences and randomized traffic against
//               a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        pc_en;
  logic        pc_mux_en;
  logic        IR_enable;
  logic [15:0] mem_data_in;
  logic [15:0] pc_out;
  logic [7:0]  opcode_out;
  logic [4:0]  rdst_out;
  logic [4:0]  rsrc_out;
  logic [7:0]  immediate_out;
  logic [3:0]  flag_type_out;
  logic        instr_valid;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] pc_m;
  logic [15:0] ir_m;
  logic        v_m;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_en         (pc_en),
    .pc_mux_en     (pc_mux_en),
    .IR_enable     (IR_enable),
    .mem_data_in   (mem_data_in),
    .pc_out        (pc_out),
    .opcode_out    (opcode_out),
    .rdst_out      (rdst_out),
    .rsrc_out      (rsrc_out),
    .immediate_out (immediate_out),
    .flag_type_out (flag_type_out),
    .instr_valid   (instr_valid),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [7:0]  imm;
    logic [3:0]  cls;
    logic        ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction class straight from the decode table
  function automatic logic [4:0] ref_class(input logic [15:0] w);
    logic [3:0] hi;
    logic [3:0] ex;
    hi = w[15:12];
    ex = w[7:4];
    if (hi == 4'h0) return {1'b0, 4'b0001};
    if (hi == 4'h4 && ex == 4'h0) return {1'b0, 4'b0100};
    if (hi == 4'h4 && ex == 4'h4) return {1'b0, 4'b0101};
    if (hi == 4'h4 && ex == 4'hC) return {1'b0, 4'b0110};
    if (hi == 4'hC) return {1'b0, 4'b0011};
    if (hi == 4'h1 || hi == 4'h5 || hi == 4'h9 || hi == 4'hB || hi == 4'hD || hi == 4'h3)
      return {1'b0, 4'b0010};
    return {1'b1, 4'b0000};
  endfunction

  task automatic compare_all(input string tag);
    logic [4:0] c;
    c = ref_class(ir_m);
    check({tag, ".pc"},    pc_out, pc_m);
    check({tag, ".valid"}, instr_valid, v_m);
    check({tag, ".opc"},   opcode_out,    v_m ? {ir_m[15:12], ir_m[7:4]} : 8'h00);
    check({tag, ".rd"},    rdst_out,      v_m ? {1'b0, ir_m[11:8]} : 5'd0);
    check({tag, ".rs"},    rsrc_out,      v_m ? {1'b0, ir_m[3:0]}  : 5'd0);
    check({tag, ".imm"},   immediate_out, v_m ? ir_m[7:0] : 8'h00);
    check({tag, ".cls"},   flag_type_out, v_m ? c[3:0] : 4'h0);
    check({tag, ".ill"},   illegal,       v_m ? c[4] : 1'b0);
  endtask

  task automatic model_reset();
    pc_m = 16'h0000;
    ir_m = 16'h0000;
    v_m  = 1'b0;
  endtask

  // One clock with the given strobes; model advances from pre-edge values.
  task automatic step(input logic pe, input logic pm, input logic ie,
                      input logic [15:0] md, input string tag);
    logic [15:0] npc;
    pc_en = pe; pc_mux_en = pm; IR_enable = ie; mem_data_in = md;
    npc = pc_m;
    if (pe) begin
      if (pm) npc = 16'(int'(pc_m) + int'($signed(ir_m[7:0])));
      else    npc = 16'(int'(pc_m) + 1);
    end
    @(posedge clk);
    #1;
    pc_m = npc;
    if (ie) begin
      ir_m = md;
      v_m  = 1'b1;
    end
    pc_en = 1'b0; pc_mux_en = 1'b0; IR_enable = 1'b0;
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pc_en = 1'b0; pc_mux_en = 1'b0; IR_enable = 1'b0; mem_data_in = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all("reset");
  endtask

  // Walk the PC to a target using branch displacements (leaves IR modified).
  task automatic goto_pc(input logic [15:0] target);
    for (int k = 0; k < 600 && pc_m != target; k++) begin
      logic signed [15:0] d;
      logic [7:0]         imm;
      d = $signed(target - pc_m);
      if (d >= -128 && d <= 127) imm = d[7:0];
      else imm = 8'd127;
      step(1'b0, 1'b0, 1'b1, {8'hC0, imm}, "goto_ld");
      step(1'b1, 1'b1, 1'b0, 16'h0000,     "goto_br");
    end
    check("goto_pc", pc_out, target);
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    pc_en = 1'b0; pc_mux_en = 1'b0; IR_enable = 1'b0; mem_data_in = 16'h0000;
    model_reset();

    vecs.push_back('{16'h0512, 8'h01, 5'd5,  5'd2,  8'h12, 4'b0001, 1'b0});
    vecs.push_back('{16'h4005, 8'h40, 5'd0,  5'd5,  8'h05, 4'b0100, 1'b0});
    vecs.push_back('{16'h4344, 8'h44, 5'd3,  5'd4,  8'h44, 4'b0101, 1'b0});
    vecs.push_back('{16'h40C7, 8'h4C, 5'd0,  5'd7,  8'hC7, 4'b0110, 1'b0});
    vecs.push_back('{16'h4080, 8'h48, 5'd0,  5'd0,  8'h80, 4'b0000, 1'b1});
    vecs.push_back('{16'hC0FE, 8'hCF, 5'd0,  5'd14, 8'hFE, 4'b0011, 1'b0});
    vecs.push_back('{16'h1ABC, 8'h1B, 5'd10, 5'd12, 8'hBC, 4'b0010, 1'b0});
    vecs.push_back('{16'h3210, 8'h31, 5'd2,  5'd0,  8'h10, 4'b0010, 1'b0});
    vecs.push_back('{16'hD5A5, 8'hDA, 5'd5,  5'd5,  8'hA5, 4'b0010, 1'b0});
    vecs.push_back('{16'hF000, 8'hF0, 5'd0,  5'd0,  8'h00, 4'b0000, 1'b1});
    vecs.push_back('{16'h2345, 8'h24, 5'd3,  5'd5,  8'h45, 4'b0000, 1'b1});
    vecs.push_back('{16'h7FFF, 8'h7F, 5'd15, 5'd15, 8'hFF, 4'b0000, 1'b1});
    vecs.push_back('{16'hA000, 8'hA0, 5'd0,  5'd0,  8'h00, 4'b0000, 1'b1});

    do_reset();

    // Decode table
    foreach (vecs[i]) begin
      step(1'b0, 1'b0, 1'b1, vecs[i].word, "vec");
      check("vec.opc", opcode_out,    vecs[i].opc);
      check("vec.rd",  rdst_out,      vecs[i].rd);
      check("vec.rs",  rsrc_out,      vecs[i].rs);
      check("vec.imm", immediate_out, vecs[i].imm);
      check("vec.cls", flag_type_out, vecs[i].cls);
      check("vec.ill", illegal,       vecs[i].ill);
    end

    // Sequential fetch
    do_reset();
    step(1'b1, 1'b0, 1'b1, 16'h0512, "seq1");
    check("seq1.pc", pc_out, 16'd1);
    check("seq1.cls", flag_type_out, 4'b0001);
    check("seq1.opc", opcode_out, 8'h01);
    check("seq1.rd", rdst_out, 5'd5);
    check("seq1.rs", rsrc_out, 5'd2);
    step(1'b1, 1'b0, 1'b1, 16'h4005, "seq2");
    check("seq2.pc", pc_out, 16'd2);
    check("seq2.cls", flag_type_out, 4'b0100);
    step(1'b1, 1'b0, 1'b1, 16'h4344, "seq3");
    check("seq3.pc", pc_out, 16'd3);
    check("seq3.cls", flag_type_out, 4'b0101);

    // Branch displacement
    do_reset();
    goto_pc(16'h0010);
    step(1'b0, 1'b0, 1'b1, 16'hC0FE, "br_ld");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "br_neg");
    check("br_neg.pc", pc_out, 16'h000E);
    do_reset();
    goto_pc(16'h0010);
    step(1'b0, 1'b0, 1'b1, 16'hC07F, "br_ld2");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "br_pos");
    check("br_pos.pc", pc_out, 16'h008F);

    // Wrap-around
    do_reset();
    goto_pc(16'hFFFF);
    step(1'b1, 1'b0, 1'b0, 16'h0000, "wrap_inc");
    check("wrap_inc.pc", pc_out, 16'h0000);
    goto_pc(16'hFFFF);
    step(1'b0, 1'b0, 1'b1, 16'hC002, "wrap_ld");
    step(1'b1, 1'b1, 1'b0, 16'h0000, "wrap_br");
    check("wrap_br.pc", pc_out, 16'h0001);

    // Simultaneous PC advance and fetch
    do_reset();
    goto_pc(16'h0004);
    step(1'b0, 1'b0, 1'b1, 16'hC003, "sim_ld");
    step(1'b1, 1'b1, 1'b1, 16'h0102, "sim");
    check("sim.pc",  pc_out, 16'h0007);
    check("sim.imm", immediate_out, 8'h02);
    check("sim.opc", opcode_out, 8'h00);
    check("sim.cls", flag_type_out, 4'b0001);

    // Illegal word, then hold with toggling memory
    step(1'b0, 1'b0, 1'b1, 16'hF000, "ill");
    check("ill.cls", flag_type_out, 4'b0000);
    check("ill.flag", illegal, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 16'h0512 : 16'hC0FE, "hold");
      check("hold.pc",  pc_out, 16'h0007);
      check("hold.opc", opcode_out, 8'hF0);
      check("hold.ill", illegal, 1'b1);
    end

    // Asynchronous reset mid-run
    do_reset();
    goto_pc(16'h0005);
    step(1'b0, 1'b0, 1'b1, 16'h4123, "arst_ld");
    #2;
    pc_en = 1'b1; IR_enable = 1'b1; mem_data_in = 16'h0512;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst.pc",    pc_out, 16'h0000);
    check("arst.valid", instr_valid, 1'b0);
    check("arst.cls",   flag_type_out, 4'h0);
    check("arst.ill",   illegal, 1'b0);
    @(posedge clk);
    #1;
    compare_all("arst_hold");
    pc_en = 1'b0; IR_enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    compare_all("arst_rel");

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] w;
      logic [3:0]  hi;
      hi = 4'($urandom_range(0, 15));
      w  = {hi, 12'($urandom)};
      if ($urandom_range(0, 3) == 0) w[7:4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hC;
      step(1'($urandom), 1'($urandom), 1'($urandom), w, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
